// File: rtl/conv_stream_folded.sv
// Streaming 1-D valid convolution with a folded MAC: LANES multipliers are time-shared
// over F_SIZE/LANES cycles per output while a shift-register window slides over X.
module conv_stream_folded #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int LANES        = 4,
  parameter int Y_WIDTH      = 16,
  parameter int SAT_EN       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  input  logic [DATA_WIDTH_F-1:0] s_data_in_f,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic                    relu_en,
  output logic [Y_WIDTH-1:0]      m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);
  localparam int ACC_W   = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE);
  localparam int PW      = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int EXT_W   = (Y_WIDTH > ACC_W) ? Y_WIDTH : ACC_W;
  localparam int MAC_CYC = F_SIZE / LANES;
  localparam int NOUT    = X_SIZE - F_SIZE + 1;
  localparam int CW      = $clog2(F_SIZE + 1);
  localparam int IW      = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
  localparam int MCW     = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;
  localparam int OCW     = $clog2(NOUT + 1);

  localparam logic [CW-1:0]  F_FULL   = CW'(F_SIZE);
  localparam logic [MCW-1:0] MAC_LAST = MCW'(MAC_CYC - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(NOUT - 1);
  localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-Y_WIDTH+1){1'b0}}, {(Y_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-Y_WIDTH+1){1'b1}}, {(Y_WIDTH-1){1'b0}}};

  // Handshake rule for every port pair: a beat moves on the rising clk edge where
  // valid && ready are both high; ready is a function of registered state only.
  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT, S_SHIFT} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH_X-1:0] win   [F_SIZE];
  logic signed [DATA_WIDTH_F-1:0] f_mem [F_SIZE];
  logic [CW-1:0]           f_cnt, x_cnt;
  logic [MCW-1:0]          mac_cnt;
  logic [OCW-1:0]          out_cnt;
  logic signed [ACC_W-1:0] acc, lane_sum, acc_nxt;
  logic signed [PW-1:0]    lane_prod;
  logic [IW-1:0]           lane_idx;
  logic                    relu_q, valid_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic                    f_fire, x_fire, y_fire, load_full, mac_last, out_last;

  assign f_fire    = s_valid_f && s_ready_f;
  assign x_fire    = s_valid_x && s_ready_x;
  assign y_fire    = m_valid_y && m_ready_y;
  assign load_full = (f_cnt == F_FULL) && (x_cnt == F_FULL);
  assign mac_last  = (mac_cnt == MAC_LAST);
  assign out_last  = (out_cnt == OUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (load_full) state_nxt = S_MAC;
      S_MAC:   if (mac_last)  state_nxt = S_OUT;
      S_OUT:   if (y_fire)    state_nxt = out_last ? S_LOAD : S_SHIFT;
      S_SHIFT: if (x_fire)    state_nxt = S_MAC;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    s_ready_f    = reset && (state == S_LOAD) && (f_cnt != F_FULL);
    s_ready_x    = reset && (((state == S_LOAD) && (x_cnt != F_FULL)) || (state == S_SHIFT));
    m_valid_y    = valid_q;
    m_data_out_y = y_q;
  end

  // Partial dot product of the taps handled in the current MAC cycle.
  always_comb begin
    lane_sum  = '0;
    lane_idx  = '0;
    lane_prod = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx  = IW'(int'(mac_cnt) * LANES + l);
      lane_prod = win[lane_idx] * f_mem[lane_idx];
      lane_sum  = lane_sum + ACC_W'(lane_prod);
    end
    acc_nxt = acc + lane_sum;
  end

  function automatic logic [Y_WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                   input logic relu);
    logic signed [EXT_W-1:0] v;
    v = EXT_W'(a);
    if (relu && (v < 0)) v = '0;
    if (SAT_EN != 0) begin
      if (v > Y_MAX)      v = Y_MAX;
      else if (v < Y_MIN) v = Y_MIN;
    end
    return v[Y_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      f_cnt   <= '0;
      x_cnt   <= '0;
      mac_cnt <= '0;
      out_cnt <= '0;
      acc     <= '0;
      relu_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      if (f_fire) begin
        f_mem[f_cnt[IW-1:0]] <= s_data_in_f;
        f_cnt                <= f_cnt + 1'b1;
        if (f_cnt == '0) relu_q <= relu_en;
      end
      // The window always shifts on an X beat, so after F_SIZE loads win[0] holds the oldest sample.
      if (x_fire) begin
        for (int i = 0; i < F_SIZE - 1; i++) win[i] <= win[i+1];
        win[F_SIZE-1] <= s_data_in_x;
        if (state == S_LOAD) x_cnt <= x_cnt + 1'b1;
      end
      case (state)
        S_LOAD: if (load_full) begin
          acc     <= '0;
          mac_cnt <= '0;
        end
        S_MAC: begin
          acc     <= acc_nxt;
          mac_cnt <= mac_cnt + 1'b1;
          if (mac_last) begin
            y_q     <= post_proc(acc_nxt, relu_q);
            valid_q <= 1'b1;
          end
        end
        S_OUT: if (y_fire) begin
          valid_q <= 1'b0;
          out_cnt <= out_cnt + 1'b1;
          if (out_last) begin
            f_cnt   <= '0;
            x_cnt   <= '0;
            out_cnt <= '0;
          end
        end
        S_SHIFT: if (x_fire) begin
          acc     <= '0;
          mac_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_folded.sv
// Directed bench for conv_stream_folded (X_SIZE=8, F_SIZE=4, LANES=2): drivers feed F/X,
// a monitor pops hand-computed results from a queue whenever an output is presented.
module tb_conv_stream_folded;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data_in_x, s_data_in_f;
  logic        s_valid_x, s_valid_f, s_ready_x, s_ready_f;
  logic        relu_en;
  logic [15:0] m_data_out_y;
  logic        m_valid_y, m_ready_y;

  conv_stream_folded #(
    .DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(8), .F_SIZE(4),
    .LANES(2), .Y_WIDTH(16), .SAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .relu_en(relu_en),
    .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0]       exp_q[$];
  logic signed [7:0] f_vec [4];
  logic signed [7:0] x_vec [8];
  logic [15:0]       exp_vec [5];
  int  n_checks = 0, n_pass = 0, n_out = 0;
  int  lat_cyc = 0, t4_cyc = 0;
  logic stall_mode = 1'b0, abort = 1'b0, lat_arm = 1'b0;
  logic [15:0] held, e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // driver tasks
  task automatic drive_f();
    for (int i = 0; i < 4 && !abort; i++) begin
      int  w = 0;
      bit  done = 0;
      s_data_in_f = f_vec[i];
      s_valid_f   = 1'b1;
      while (!done && !abort) begin
        @(negedge clk);
        if (!abort && s_ready_f) begin
          @(posedge clk); #1;
          done = 1;
        end else if (++w > 400) begin
          timeout_fail("f_beat");
          abort = 1'b1;
        end
      end
    end
    s_valid_f = 1'b0;
  endtask

  task automatic drive_x();
    for (int i = 0; i < 8 && !abort; i++) begin
      int  w = 0;
      bit  done = 0;
      s_data_in_x = x_vec[i];
      s_valid_x   = 1'b1;
      while (!done && !abort) begin
        @(negedge clk);
        if (!abort && s_ready_x) begin
          @(posedge clk); #1;
          done = 1;
          if (i == 3) t4_cyc = cyc;
        end else if (++w > 400) begin
          timeout_fail("x_beat");
          abort = 1'b1;
        end
      end
    end
    s_valid_x = 1'b0;
  endtask

  task automatic push_exp();
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_vec[i]);
  endtask

  task automatic run_vec(input logic relu, input logic stall);
    int w = 0;
    relu_en    = relu;
    stall_mode = stall;
    push_exp();
    fork
      drive_f();
      drive_x();
    join
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("outputs_drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
    check("ready_f_after_vector", 32'(s_ready_f), 32'd1);
    stall_mode = 1'b0;
  endtask

  task automatic set_t1();
    f_vec   = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    x_vec   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    exp_vec = '{16'd10, 16'd14, 16'd18, 16'd22, 16'd26};
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset && m_valid_y) begin
        if (lat_arm) begin
          lat_cyc = cyc;
          lat_arm = 1'b0;
        end
        if (stall_mode) begin
          m_ready_y = 1'b0;
          held      = m_data_out_y;
          repeat (10) begin
            @(negedge clk);
            check("hold_data_stable", 32'(m_data_out_y), 32'(held));
            check("hold_valid", 32'(m_valid_y), 32'd1);
            check("hold_ready_x_low", 32'(s_ready_x), 32'd0);
          end
          m_ready_y = 1'b1;
        end
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("y_value", 32'(m_data_out_y), 32'(e));
        end
        n_out++;
      end
    end
  end

  initial begin
    int base;
    int w;
    reset = 1'b0;
    s_valid_x = 1'b0; s_valid_f = 1'b0; s_data_in_x = '0; s_data_in_f = '0;
    relu_en = 1'b0; m_ready_y = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_x", 32'(s_ready_x), 32'd0);
    check("rst_ready_f", 32'(s_ready_f), 32'd0);
    check("rst_valid_y", 32'(m_valid_y), 32'd0);
    check("rst_data_y", 32'(m_data_out_y), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready_f", 32'(s_ready_f), 32'd1);
    check("post_rst_ready_x", 32'(s_ready_x), 32'd1);

    // 1: box filter over a ramp
    set_t1();
    run_vec(1'b0, 1'b0);

    // 2: saturation both ways
    f_vec   = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
    x_vec   = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
    exp_vec = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_vec(1'b0, 1'b0);
    x_vec   = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128};
    exp_vec = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_vec(1'b0, 1'b0);

    // 3: alternating taps, with and without ReLU
    f_vec   = '{8'sd1, -8'sd1, 8'sd1, -8'sd1};
    x_vec   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    exp_vec = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_vec(1'b1, 1'b0);
    exp_vec = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    run_vec(1'b0, 1'b0);

    // 4: output back-pressure
    set_t1();
    run_vec(1'b0, 1'b1);

    // 5: reset pulse after the third output, then rerun
    set_t1();
    relu_en = 1'b0;
    base = n_out;
    push_exp();
    fork
      begin
        fork
          drive_f();
          drive_x();
        join
      end
      begin
        w = 0;
        while (n_out < base + 3 && w < 2000) begin
          @(negedge clk);
          w++;
        end
        if (n_out < base + 3) timeout_fail("third_output");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid_y", 32'(m_valid_y), 32'd0);
        check("midrst_data_y", 32'(m_data_out_y), 32'd0);
        check("midrst_ready_x", 32'(s_ready_x), 32'd0);
        check("midrst_ready_f", 32'(s_ready_f), 32'd0);
        abort = 1'b1;
        reset = 1'b1;
      end
    join
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    check("midrst_outputs_before_reset", 32'(n_out - base), 32'd3);
    exp_q.delete();
    abort = 1'b0;
    @(posedge clk); #1;
    check("midrst_back_to_load", 32'(s_ready_f), 32'd1);
    check("midrst_no_valid", 32'(m_valid_y), 32'd0);
    run_vec(1'b0, 1'b0);

    // 6: latency from the 4th X beat to the first result
    set_t1();
    lat_arm = 1'b1;
    run_vec(1'b0, 1'b0);
    check("latency", 32'(lat_cyc - t4_cyc), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
